// File: rtl/intseq_if.sv
// Interrupt sequencer bus: device requests, PSW/microsequencer handshake and vector output.
// Optional mask-write signals D/MWE exist only when INTSEQ_INTMASK_EN is defined.
interface intseq_if #(
  parameter int unsigned NIRQ = 8
);
  logic [NIRQ-1:0] IRQ;
  logic            IE;
  logic            FETCH;
  logic            INTACK;
  logic            VRE;
`ifdef INTSEQ_INTMASK_EN
  logic [15:0]     D;
  logic            MWE;
`endif
  logic            INTREQ;
  logic            IECLR;
  logic [NIRQ-1:0] IRQACK;
  logic            ACTIVE;
  logic [15:0]     Q;

  modport master (
    output IRQ, IE, FETCH, INTACK, VRE,
`ifdef INTSEQ_INTMASK_EN
    output D, MWE,
`endif
    input  INTREQ, IECLR, IRQACK, ACTIVE, Q
  );

  modport slave (
    input  IRQ, IE, FETCH, INTACK, VRE,
`ifdef INTSEQ_INTMASK_EN
    input  D, MWE,
`endif
    output INTREQ, IECLR, IRQACK, ACTIVE, Q
  );
endinterface

// File: rtl/intseq.sv
// Interrupt sequencer: priority arbitration, trap request, IE clear, device ack and vector delivery.
// Optional macro INTSEQ_INTMASK_EN adds a software-writable per-line request mask.
module intseq #(
  parameter int unsigned NIRQ  = 8,
  parameter logic [15:0] VBASE = 16'h0010
) (
  input logic   CLOCK,
  input logic   RESET,
  intseq_if.slave bus
);

  localparam int unsigned LW = (NIRQ > 1) ? $clog2(NIRQ) : 1;

  typedef enum logic [1:0] {IDLE, PEND, ACK, VECT} state_t;

  state_t          state_q, state_d;
  logic [LW-1:0]   vlvl_q;
  logic [LW-1:0]   lvl;
  logic [NIRQ-1:0] mask;
  logic [NIRQ-1:0] ereq;
  logic            any_req;
  logic            intreq_q, ieclr_q, active_q;
  logic [NIRQ-1:0] irqack_q;
  logic [15:0]     vec;

`ifdef INTSEQ_INTMASK_EN
  logic [NIRQ-1:0] mask_q;
  logic            d_unused;

  // Mask write takes effect for arbitration from the following cycle
  always_ff @(posedge CLOCK) begin
    if (RESET)        mask_q <= '1;
    else if (bus.MWE) mask_q <= bus.D[NIRQ-1:0];
  end

  assign mask     = mask_q;
  assign d_unused = ^bus.D;
`else
  assign mask = '1;
`endif

  assign ereq    = bus.IRQ & mask;
  assign any_req = |ereq;

  // Highest set bit of the effective request vector wins
  always_comb begin
    lvl = '0;
    for (int unsigned i = 0; i < NIRQ; i++) begin
      if (ereq[i]) lvl = LW'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (bus.IE && any_req) state_d = PEND;
      PEND: begin
        if (!bus.IE || !any_req)           state_d = IDLE;
        else if (bus.FETCH && bus.INTACK)  state_d = ACK;
      end
      ACK:  state_d = VECT;
      VECT: if (bus.VRE) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered decodes of the next state, so they depend on state only
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q  <= IDLE;
      vlvl_q   <= '0;
      intreq_q <= 1'b0;
      ieclr_q  <= 1'b0;
      active_q <= 1'b0;
      irqack_q <= '0;
    end else begin
      state_q  <= state_d;
      if (state_q == PEND && state_d == ACK) vlvl_q <= lvl;
      intreq_q <= (state_d == PEND);
      ieclr_q  <= (state_d == ACK);
      active_q <= (state_d == ACK) || (state_d == VECT);
      irqack_q <= (state_d == ACK) ? (NIRQ'(1) << lvl) : '0;
    end
  end

  assign vec = VBASE + 16'({vlvl_q, 2'b00});

  assign bus.INTREQ = intreq_q;
  assign bus.IECLR  = ieclr_q;
  assign bus.IRQACK = irqack_q;
  assign bus.ACTIVE = active_q;
  assign bus.Q      = (state_q == VECT && bus.VRE) ? vec : 16'h0000;

endmodule

// File: tb/tb_intseq.sv
// Self-checking bench for intseq: directed scenarios plus randomized traffic against a behavioural model.
// Mask scenarios are compiled in when INTSEQ_INTMASK_EN is defined.
module tb_intseq;

  localparam int unsigned NIRQ  = 8;
  localparam logic [15:0] VBASE = 16'h0010;

  logic CLOCK = 1'b0;
  logic RESET = 1'b1;
  int   nvec  = 0;
  int   nerr  = 0;

  intseq_if #(.NIRQ(NIRQ)) bus ();

  intseq #(.NIRQ(NIRQ), .VBASE(VBASE)) dut (
    .CLOCK (CLOCK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLOCK = ~CLOCK;

  // Behavioural model: pending flag, trap phase (0 none, 1 ack cycle, 2 awaiting VRE), winning level
  bit              m_pend = 0;
  int              m_trap = 0;
  int              m_lvl  = 0;
  logic [NIRQ-1:0] m_mask = '1;

  function automatic int top_level(input logic [NIRQ-1:0] v);
    int r = 0;
    for (int i = 0; i < NIRQ; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic model_step();
    logic [NIRQ-1:0] req;
    req = bus.IRQ & m_mask;
    if (RESET) begin
      m_pend = 0; m_trap = 0; m_lvl = 0; m_mask = '1;
    end else begin
      if (m_trap == 1) m_trap = 2;
      else if (m_trap == 2) begin
        if (bus.VRE) m_trap = 0;
      end else if (m_pend) begin
        if (!bus.IE || req == '0) m_pend = 0;
        else if (bus.FETCH && bus.INTACK) begin
          m_pend = 0; m_trap = 1; m_lvl = top_level(req);
        end
      end else if (bus.IE && req != '0) m_pend = 1;
`ifdef INTSEQ_INTMASK_EN
      if (bus.MWE) m_mask = bus.D[NIRQ-1:0];
`endif
    end
  endtask

  task automatic tick();
    @(posedge CLOCK);
    model_step();
    @(negedge CLOCK);
  endtask

  task automatic idle_inputs();
    bus.IRQ = '0; bus.IE = 1'b0; bus.FETCH = 1'b0; bus.INTACK = 1'b0; bus.VRE = 1'b0;
`ifdef INTSEQ_INTMASK_EN
    bus.D = 16'h0000; bus.MWE = 1'b0;
`endif
  endtask

  task automatic do_reset();
    idle_inputs();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
  endtask

  task automatic test_reset();
    bus.IRQ = 8'hFF; bus.IE = 1'b1; bus.VRE = 1'b1;
    RESET = 1'b1;
    tick(); tick();
    nvec++; if (bus.INTREQ !== 1'b0) begin nerr++; $display("FAIL reset_intreq got %b want 0", bus.INTREQ); end
    nvec++; if (bus.IECLR  !== 1'b0) begin nerr++; $display("FAIL reset_ieclr got %b want 0", bus.IECLR); end
    nvec++; if (bus.IRQACK !== 8'h00) begin nerr++; $display("FAIL reset_irqack got %h want 00", bus.IRQACK); end
    nvec++; if (bus.ACTIVE !== 1'b0) begin nerr++; $display("FAIL reset_active got %b want 0", bus.ACTIVE); end
    nvec++; if (bus.Q !== 16'h0000) begin nerr++; $display("FAIL reset_q got %h want 0000", bus.Q); end
    RESET = 1'b0;
    tick();
    nvec++; if (bus.INTREQ !== 1'b1) begin nerr++; $display("FAIL reset_rerequest got %b want 1", bus.INTREQ); end
  endtask

  task automatic test_priority();
    do_reset();
    bus.IRQ = 8'b0010_0100; bus.IE = 1'b1;
    tick();
    nvec++; if (bus.INTREQ !== 1'b1) begin nerr++; $display("FAIL prio_intreq got %b want 1", bus.INTREQ); end
    bus.FETCH = 1'b1; bus.INTACK = 1'b1;
    tick();
    bus.FETCH = 1'b0; bus.INTACK = 1'b0; bus.IE = 1'b0; bus.VRE = 1'b1;
    nvec++; if (bus.IECLR !== 1'b1) begin nerr++; $display("FAIL prio_ieclr got %b want 1", bus.IECLR); end
    nvec++; if (bus.IRQACK !== 8'h20) begin nerr++; $display("FAIL prio_irqack got %h want 20", bus.IRQACK); end
    nvec++; if (bus.INTREQ !== 1'b0) begin nerr++; $display("FAIL prio_intreq_ack got %b want 0", bus.INTREQ); end
    tick();
    nvec++; if (bus.Q !== 16'h0024) begin nerr++; $display("FAIL prio_vector got %h want 0024", bus.Q); end
    nvec++; if (bus.IECLR !== 1'b0) begin nerr++; $display("FAIL prio_ieclr_once got %b want 0", bus.IECLR); end
    tick();
    nvec++; if (bus.Q !== 16'h0000) begin nerr++; $display("FAIL prio_q_after got %h want 0000", bus.Q); end
    nvec++; if (bus.ACTIVE !== 1'b0) begin nerr++; $display("FAIL prio_idle_active got %b want 0", bus.ACTIVE); end
  endtask

  task automatic test_overtake_withdraw();
    do_reset();
    bus.IRQ = 8'h04; bus.IE = 1'b1;
    tick();
    bus.IRQ = 8'h84;
    tick();
    bus.FETCH = 1'b1; bus.INTACK = 1'b1;
    tick();
    bus.FETCH = 1'b0; bus.INTACK = 1'b0; bus.IE = 1'b0; bus.VRE = 1'b1;
    nvec++; if (bus.IRQACK !== 8'h80) begin nerr++; $display("FAIL overtake_irqack got %h want 80", bus.IRQACK); end
    tick();
    nvec++; if (bus.Q !== 16'h002C) begin nerr++; $display("FAIL overtake_vector got %h want 002C", bus.Q); end
    tick();
    do_reset();
    bus.IRQ = 8'h04; bus.IE = 1'b1;
    tick();
    bus.IRQ = 8'h00;
    tick();
    nvec++; if (bus.INTREQ !== 1'b0) begin nerr++; $display("FAIL withdraw_intreq got %b want 0", bus.INTREQ); end
    bus.FETCH = 1'b1; bus.INTACK = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      nvec++; if (bus.IECLR !== 1'b0) begin nerr++; $display("FAIL withdraw_ieclr got %b want 0", bus.IECLR); end
    end
  endtask

  task automatic test_ie_gating();
    do_reset();
    bus.IRQ = 8'h01; bus.IE = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      nvec++; if (bus.INTREQ !== 1'b0) begin nerr++; $display("FAIL iegate_intreq got %b want 0", bus.INTREQ); end
    end
    bus.IE = 1'b1;
    tick();
    bus.IE = 1'b0; bus.FETCH = 1'b1; bus.INTACK = 1'b1;
    tick();
    nvec++; if (bus.IECLR !== 1'b0) begin nerr++; $display("FAIL iedrop_ieclr got %b want 0", bus.IECLR); end
    nvec++; if (bus.IRQACK !== 8'h00) begin nerr++; $display("FAIL iedrop_irqack got %h want 00", bus.IRQACK); end
    nvec++; if (bus.INTREQ !== 1'b0) begin nerr++; $display("FAIL iedrop_intreq got %b want 0", bus.INTREQ); end
  endtask

  task automatic test_reset_mid_trap();
    do_reset();
    bus.IRQ = 8'h04; bus.IE = 1'b1;
    tick();
    bus.FETCH = 1'b1; bus.INTACK = 1'b1;
    tick();
    bus.FETCH = 1'b0; bus.INTACK = 1'b0; bus.VRE = 1'b1;
    RESET = 1'b1;
    tick();
    RESET = 1'b0; bus.IE = 1'b0;
    nvec++; if (bus.IRQACK !== 8'h00) begin nerr++; $display("FAIL rstack_irqack got %h want 00", bus.IRQACK); end
    nvec++; if (bus.ACTIVE !== 1'b0) begin nerr++; $display("FAIL rstack_active got %b want 0", bus.ACTIVE); end
    nvec++; if (bus.Q !== 16'h0000) begin nerr++; $display("FAIL rstack_q got %h want 0000", bus.Q); end
    tick();
    nvec++; if (bus.IECLR !== 1'b0) begin nerr++; $display("FAIL rstack_ieclr got %b want 0", bus.IECLR); end
    bus.VRE = 1'b0; bus.IE = 1'b1;
    tick();
    bus.FETCH = 1'b1; bus.INTACK = 1'b1;
    tick();
    bus.FETCH = 1'b0; bus.INTACK = 1'b0; bus.IE = 1'b0;
    tick();
    nvec++; if (bus.ACTIVE !== 1'b1) begin nerr++; $display("FAIL vectwait_active got %b want 1", bus.ACTIVE); end
    nvec++; if (bus.Q !== 16'h0000) begin nerr++; $display("FAIL vectwait_q got %h want 0000", bus.Q); end
    RESET = 1'b1; bus.VRE = 1'b1;
    #1;
    nvec++; if (bus.Q !== 16'h0018) begin nerr++; $display("FAIL vect_comb_q got %h want 0018", bus.Q); end
    tick();
    RESET = 1'b0;
    nvec++; if (bus.Q !== 16'h0000) begin nerr++; $display("FAIL rstvect_q got %h want 0000", bus.Q); end
    nvec++; if (bus.ACTIVE !== 1'b0) begin nerr++; $display("FAIL rstvect_active got %b want 0", bus.ACTIVE); end
    nvec++; if (bus.IRQACK !== 8'h00) begin nerr++; $display("FAIL rstvect_irqack got %h want 00", bus.IRQACK); end
  endtask

`ifdef INTSEQ_INTMASK_EN
  task automatic test_mask();
    do_reset();
    bus.MWE = 1'b1; bus.D = 16'h00FB;
    tick();
    bus.MWE = 1'b0; bus.IRQ = 8'h04; bus.IE = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      nvec++; if (bus.INTREQ !== 1'b0) begin nerr++; $display("FAIL mask_block got %b want 0", bus.INTREQ); end
    end
    bus.MWE = 1'b1; bus.D = 16'h00FF;
    tick();
    bus.MWE = 1'b0;
    nvec++; if (bus.INTREQ !== 1'b0) begin nerr++; $display("FAIL mask_write_edge got %b want 0", bus.INTREQ); end
    tick();
    nvec++; if (bus.INTREQ !== 1'b1) begin nerr++; $display("FAIL mask_unblock got %b want 1", bus.INTREQ); end
  endtask
`endif

  // Randomized traffic compared cycle by cycle with the behavioural model
  task automatic test_random();
    logic [NIRQ-1:0] e_ack;
    logic [15:0]     e_q;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      RESET      = ($urandom_range(0, 96) == 0);
      bus.IRQ    = ($urandom_range(0, 4) == 0) ? '0
                   : NIRQ'($urandom) & NIRQ'($urandom) & NIRQ'($urandom);
      bus.IE     = ($urandom_range(0, 7) != 0);
      bus.FETCH  = ($urandom_range(0, 2) == 0);
      bus.INTACK = ($urandom_range(0, 1) == 0);
      bus.VRE    = ($urandom_range(0, 2) == 0);
`ifdef INTSEQ_INTMASK_EN
      bus.MWE    = ($urandom_range(0, 40) == 0);
      bus.D      = 16'($urandom);
`endif
      tick();
      e_ack = (m_trap == 1) ? NIRQ'(1 << m_lvl) : '0;
      e_q   = (m_trap == 2 && bus.VRE) ? 16'(int'(VBASE) + 4 * m_lvl) : 16'h0000;
      nvec++; if (bus.INTREQ !== m_pend) begin nerr++; $display("FAIL rnd_intreq cyc %0d got %b want %b", n, bus.INTREQ, m_pend); end
      nvec++; if (bus.IECLR !== (m_trap == 1)) begin nerr++; $display("FAIL rnd_ieclr cyc %0d got %b want %b", n, bus.IECLR, m_trap == 1); end
      nvec++; if (bus.IRQACK !== e_ack) begin nerr++; $display("FAIL rnd_irqack cyc %0d got %h want %h", n, bus.IRQACK, e_ack); end
      nvec++; if (bus.ACTIVE !== (m_trap != 0)) begin nerr++; $display("FAIL rnd_active cyc %0d got %b want %b", n, bus.ACTIVE, m_trap != 0); end
      nvec++; if (bus.Q !== e_q) begin nerr++; $display("FAIL rnd_q cyc %0d got %h want %h", n, bus.Q, e_q); end
    end
    RESET = 1'b0;
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_priority();
    test_overtake_withdraw();
    test_ie_gating();
    test_reset_mid_trap();
`ifdef INTSEQ_INTMASK_EN
    test_mask();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/intseq.md
# intseq

Interrupt sequencer: the requesting side of the processor status word's interrupt-enable bit. It samples device interrupt lines, arbitrates by priority, and raises a trap request to the microsequencer at an instruction boundary whenever the PSW IE bit is set. On acceptance it clears IE through the PSW's IECLR input, acknowledges the winning device, and gates the trap vector onto the data bus.

## Interface
- NIRQ, default 8: number of interrupt lines, 1..16.
- VBASE, default 16'h0010: base address of the vector table.
- CLOCK  in  1  clock; all state changes on the rising edge.
- RESET  in  1  synchronous, active-high reset, sampled on the CLOCK rising edge.
- IRQ  in  NIRQ  level-sensitive device requests. Bit n is level n; higher index has higher priority.
- IE  in  1  PSW interrupt-enable bit.
- FETCH  in  1  instruction-boundary strobe from the microsequencer.
- INTACK  in  1  microsequencer accepts the trap; meaningful only together with FETCH.
- VRE  in  1  gate the vector onto Q.
- D  in  16  data bus; present only with INTMASK_EN.
- MWE  in  1  mask write enable; present only with INTMASK_EN.
- INTREQ  out  1  trap request to the microsequencer.
- IECLR  out  1  one-cycle pulse to the PSW that clears IE.
- IRQACK  out  NIRQ  one-hot, one-cycle acknowledge to the winning device.
- ACTIVE  out  1  high while the sequencer is between acceptance and vector delivery.
- Q  out  16  the vector while VRE is high in state VECT; 16'h0000 otherwise.

## Operation
- The state register has four states: IDLE, PEND, ACK and VECT.
- Effective requests are `ereq = IRQ & mask`. Without INTMASK_EN the mask is all ones.
- `lvl` is the index of the highest set bit of ereq.
- **IDLE:**
  - Goes to PEND when `IE & |ereq`.
  - All outputs are 0.
- **PEND:**
  - INTREQ is 1.
  - `lvl` is re-evaluated every cycle, so a higher-priority request that arrives while pending overtakes the current one.
  - Returns to IDLE if `~IE | ~|ereq`. This covers software disabling interrupts and a device withdrawing its request.
  - Goes to ACK on `FETCH & INTACK & IE & |ereq`. On that edge the current `lvl` is latched into `vlvl`.
- **ACK** (exactly one cycle):
  - IECLR = 1, IRQACK = 1 << vlvl, ACTIVE = 1.
  - Always goes to VECT.
- **VECT:**
  - ACTIVE = 1.
  - Q = {16{VRE}} & (VBASE + {vlvl, 2'b00}). The sum is 16 bits and wraps modulo 2^16.
  - Goes to IDLE on the first cycle with VRE = 1. Q is valid combinationally during that cycle.
  - Waits indefinitely while VRE = 0; it is not affected by IRQ or IE.
- Once in ACK, the trap cannot be cancelled by IRQ or IE changes.

## Timing
- Reset value of every output is 0: INTREQ, IECLR, IRQACK, ACTIVE and Q. Reset puts the state in IDLE and clears vlvl.
- RESET takes priority over every other input. Asserting it in any state, including ACK, gives IDLE with all outputs 0 after the edge. An IECLR pulse is never emitted after a reset edge.
- INTREQ, IECLR, IRQACK and ACTIVE are decoded from registered state only. They have no combinational path from inputs.
- Q is the only combinational output, gated by VRE and the state.
- Latency:
  - Request: IRQ and IE high at edge t gives INTREQ high from t+1.
  - Acceptance: FETCH and INTACK at edge t' gives IECLR and IRQACK during t'+1.
  - Vector: the vector is available from t'+2 once VRE is high.
- The PSW sees IE = 0 from t'+2 onward. This is why the PEND-to-ACK transition checks IE in the same cycle.
- FETCH without INTACK, or INTACK without FETCH, has no effect.
- A request still high after return to IDLE is re-requested at the next edge, provided IE = 1.

## Configuration
- Macro INTSEQ_INTMASK_EN.
- **Defined:**
  - Adds ports D and MWE, and an NIRQ-bit mask register.
  - The mask resets to all ones.
  - `MWE = 1` at an edge loads `mask <= D[NIRQ-1:0]`. The new mask applies from the next cycle.
  - A mask write in the same cycle as PEND-to-ACK does not cancel the acceptance.
  - A mask write while in ACK or VECT only affects later arbitration.
- **Not defined:** D, MWE and the mask register are absent, and all lines are always enabled.

## Test plan
- Reset: hold RESET 2 cycles with IRQ = 8'hFF and IE = 1. All outputs are 0 and the state is IDLE. After release, INTREQ = 1 on the next cycle.
- Priority and vector: IRQ = 8'b0010_0100, IE = 1, then FETCH = INTACK = 1 for one cycle.
  - Next cycle: IECLR = 1 and IRQACK = 8'h20.
  - Then with VRE = 1: Q = 16'h0024, and the following cycle Q = 0 with the state back in IDLE.
- Overtake and withdraw:
  - In PEND at level 2, raise IRQ[7]. Acceptance acknowledges IRQACK = 8'h80, and Q = 16'h002C.
  - Separately, drop all IRQ while in PEND: INTREQ = 0 the next cycle, and IECLR never pulses.
- IE gating: IRQ[0] = 1 with IE = 0 for 10 cycles gives INTREQ = 0 throughout. Dropping IE to 0 in PEND on the same cycle as FETCH & INTACK means no ACK occurs.
- Reset mid-trap: assert RESET during the ACK cycle and again in VECT with VRE = 1. Q = 0, ACTIVE = 0 and IRQACK = 0 on the following cycle.
- With INTSEQ_INTMASK_EN: MWE = 1 with D = 16'h00FB, then IRQ = 8'h04 and IE = 1.
  - INTREQ stays 0.
  - Writing D = 16'h00FF gives INTREQ = 1 two cycles after the write edge.
